dmem_store_buffer: RTL

Memory-stage data-memory controller sitting directly downstream of the partial-word store formatter. It takes the zero-extended store data, shifts it onto the correct byte lanes, and builds byte enables. Stores are queued in a small FIFO that drains to a ready/valid data bus. Loads are serialised behind the FIFO, and the pipeline stalls until each load's raw word returns.

---
 rtl/dmem_store_buffer_if.sv | 27 ++
 rtl/dmem_store_buffer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer_if.sv
// Data-bus channel between the store buffer (master) and the memory system (slave).
// One request channel with write payload, plus a read-data return channel.
interface dmem_store_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned NumBe = DATA_WIDTH / 8;

  logic                  BusReq;
  logic                  BusWe;
  logic [ADDR_WIDTH-1:0] BusAddr;
  logic [DATA_WIDTH-1:0] BusWData;
  logic [NumBe-1:0]      BusBe;
  logic                  BusGnt;
  logic                  BusRValid;
  logic [DATA_WIDTH-1:0] BusRData;

  modport master (
    output BusReq, BusWe, BusAddr, BusWData, BusBe,
    input  BusGnt, BusRValid, BusRData
  );

  modport slave (
    input  BusReq, BusWe, BusAddr, BusWData, BusBe,
    output BusGnt, BusRValid, BusRData
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// M-stage data-memory controller: lane-aligns stores into a small FIFO that drains to the
// data bus, and serialises loads behind the FIFO while stalling the pipeline.
module dmem_store_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWriteM,
  input  logic                  MemReadM,
  input  logic [1:0]            StoreSrcM,
  input  logic [ADDR_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WritePartDataM,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  MisalignM,
  output logic                  BufEmpty,
  dmem_store_buffer_if.master   bus
);
  localparam int unsigned NumBe = DATA_WIDTH / 8;
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StWait, StReq, StResp, StDone} rd_state_e;

  rd_state_e state_q, state_d;

  logic [1:0]            offset;
  logic                  store_ok, load_ok, store_req, load_req;
  logic                  push, pop, drain, full;
  logic [NumBe-1:0]      st_be;
  logic [DATA_WIDTH-1:0] st_data;
  logic [ADDR_WIDTH-1:0] word_addr;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [NumBe-1:0]      be_mem   [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign offset    = ALUResultM[1:0];
  assign word_addr = {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
  assign store_req = MemWriteM & ~MemReadM;
  assign load_req  = MemReadM;
  assign load_ok   = (offset == 2'b00);
  assign full      = (count_q == FullCnt);
  assign BufEmpty  = (count_q == '0);

  // Lane steering: store data arrives right-aligned, so shift both data and enables by offset.
  always_comb begin
    store_ok = 1'b0;
    st_be    = '0;
    st_data  = WritePartDataM << {offset, 3'b000};
    case (StoreSrcM)
      2'b00: begin
        store_ok = (offset == 2'b00);
        st_be    = '1;
      end
      2'b01: begin
        store_ok = 1'b1;
        st_be    = NumBe'(1) << offset;
      end
      2'b10: begin
        store_ok = ~offset[0];
        st_be    = NumBe'(3) << offset;
      end
      default: store_ok = 1'b0;
    endcase
  end

  // Stores may drain only while the read FSM is not holding the bus.
  assign drain = ~BufEmpty & ((state_q == StIdle) | (state_q == StWait));
  assign pop   = drain & bus.BusGnt;
  assign push  = store_req & store_ok & ~full;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= word_addr;
      data_mem[wr_ptr_q] <= st_data;
      be_mem[wr_ptr_q]   <= st_be;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StResp) && bus.BusRValid) rdata_q <= bus.BusRData;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (load_req && load_ok) state_d = BufEmpty ? StReq : StWait;
      end
      StWait:  if (BufEmpty) state_d = StReq;
      StReq:   if (bus.BusGnt) state_d = StResp;
      StResp:  if (bus.BusRValid) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.BusReq   = 1'b0;
    bus.BusWe    = 1'b0;
    bus.BusAddr  = '0;
    bus.BusWData = '0;
    bus.BusBe    = '0;
    if (state_q == StReq) begin
      bus.BusReq  = 1'b1;
      bus.BusAddr = word_addr;
    end else if (drain) begin
      bus.BusReq   = 1'b1;
      bus.BusWe    = 1'b1;
      bus.BusAddr  = addr_mem[rd_ptr_q];
      bus.BusWData = data_mem[rd_ptr_q];
      bus.BusBe    = be_mem[rd_ptr_q];
    end
    StallM = (load_req & load_ok & (state_q != StDone)) | (store_req & full);
    // A bad store held behind a full FIFO reports only once it can actually retire.
    MisalignM = (store_req & ~store_ok & ~full) | (load_req & ~load_ok);
    ReadDataM = (load_req & ~load_ok) ? '0 : rdata_q;
  end
endmodule
